// File: rtl/instruction_sequencer.sv
// Program RAM plus issue FSM that streams 32-bit instruction words to the CPU, one per handshake.
// Optional dependency stall on src1/src2 vs the last issued dest: define ISSUE_HAZARD_STALL_EN.
module instruction_sequencer #(
  parameter int          DEPTH       = 16,
  parameter int          ALU_LATENCY = 2,
  parameter logic [31:0] HALT_WORD   = 32'hFFFF_FFFF,
  localparam int         AW          = $clog2(DEPTH)
) (
  input  logic          clock_in,
  input  logic          reset_in,
  input  logic          load_en_in,
  input  logic [AW-1:0] load_addr_in,
  input  logic [31:0]   load_data_in,
  input  logic          start_in,
  input  logic [AW-1:0] start_addr_in,
  input  logic          stop_in,
  input  logic          instr_ready_in,
  output logic [31:0]   instr_out,
  output logic          instr_valid_out,
  output logic [AW-1:0] pc_out,
  output logic          busy_out,
  output logic          done_out,
  output logic [15:0]   issued_count_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_p1, state_n;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   instr_p1, instr_n;
  logic [AW-1:0] pc_p1, pc_n;
  logic [15:0]   count_p1, count_n;
  logic [AW-1:0] pc_inc;
  logic [31:0]   next_word;
  logic [31:0]   start_word;
  logic          write_en;
  logic          accept;
  logic          stall;
  logic          clr_track;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign write_en   = load_en_in && (state_p1 != RUN) && !reset_in;
  assign pc_inc     = pc_p1 + AW'(1);
  assign next_word  = mem[pc_inc];
  // A load to the start address in the start cycle must be seen by the first fetch.
  assign start_word = (load_en_in && (load_addr_in == start_addr_in)) ? load_data_in
                                                                      : mem[start_addr_in];

  assign instr_valid_out  = (state_p1 == RUN) && !stall;
  assign accept           = instr_valid_out && instr_ready_in;
  assign instr_out        = instr_p1;
  assign pc_out           = pc_p1;
  assign busy_out         = (state_p1 == RUN);
  assign done_out         = (state_p1 == DONE);
  assign issued_count_out = count_p1;

  always_ff @(posedge clock_in) begin
    if (write_en) mem[load_addr_in] <= load_data_in;
  end

  // ---- stage p1: FSM state and presented word ----
  always_ff @(posedge clock_in) begin
    if (reset_in) state_p1 <= IDLE;
    else          state_p1 <= state_n;
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      instr_p1 <= 32'd0;
      pc_p1    <= '0;
      count_p1 <= 16'd0;
    end else begin
      instr_p1 <= instr_n;
      pc_p1    <= pc_n;
      count_p1 <= count_n;
    end
  end

  always_comb begin
    state_n   = state_p1;
    instr_n   = instr_p1;
    pc_n      = pc_p1;
    count_n   = count_p1;
    clr_track = 1'b0;
    case (state_p1)
      IDLE, DONE: begin
        if (stop_in) begin
          state_n   = IDLE;
          clr_track = 1'b1;
        end else if (start_in) begin
          pc_n      = start_addr_in;
          instr_n   = start_word;
          count_n   = 16'd0;
          clr_track = 1'b1;
          state_n   = (start_word == HALT_WORD) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          pc_n    = pc_inc;
          instr_n = next_word;
          count_n = sat_inc16(count_p1);
        end
        if (stop_in) begin
          state_n   = IDLE;
          clr_track = 1'b1;
        end else if (accept && (next_word == HALT_WORD)) begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef ISSUE_HAZARD_STALL_EN
  logic [6:0] dest_p1;
  logic [2:0] age_p1;
  logic       track_p1;

  // ---- stage p1: dependency tracking of the last accepted word ----
  always_ff @(posedge clock_in) begin
    if (reset_in || clr_track) begin
      track_p1 <= 1'b0;
      age_p1   <= 3'd0;
    end else if (accept) begin
      track_p1 <= 1'b1;
      age_p1   <= 3'd1;
    end else if (age_p1 != 3'd7) begin
      age_p1 <= age_p1 + 3'd1;
    end
  end

  always_ff @(posedge clock_in) begin
    if (accept) dest_p1 <= instr_p1[17:11];
  end

  assign stall = track_p1 &&
                 ((instr_p1[31:25] == dest_p1) || (instr_p1[24:18] == dest_p1)) &&
                 (age_p1 < 3'(ALU_LATENCY));
`else
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: directed table, corner sequences, random run.
module tb_instruction_sequencer;

  localparam int          DEPTH = 16;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
  localparam logic [31:0] WA    = 32'h1234_5678;
  localparam logic [31:0] WB    = 32'h0BAD_F00D;
  localparam logic [31:0] WC    = 32'h2468_ACE0;

  logic        clk = 1'b0;
  logic        rst, ld, st, sp, rdy;
  logic [3:0]  la, sa;
  logic [31:0] ldat;
  logic [31:0] instr;
  logic        valid, busy, done;
  logic [3:0]  pc;
  logic [15:0] cnt;

  int checks = 0;
  int failures = 0;

  // Behavioural reference: program memory plus run/done flags, pc and count.
  logic [31:0] m_mem [DEPTH];
  bit          m_run, m_done;
  int          m_pc, m_cnt;

  typedef struct {
    logic        ld;
    logic [3:0]  la;
    logic [31:0] ldat;
    logic        st;
    logic [3:0]  sa;
    logic        sp;
    logic        rdy;
    logic        ev;
    logic [31:0] ei;
    logic [3:0]  epc;
    logic        eb;
    logic        ed;
    logic [15:0] ec;
  } vec_t;

  vec_t tbl [9];

  instruction_sequencer #(.DEPTH(DEPTH), .ALU_LATENCY(2), .HALT_WORD(HALT)) dut (
    .clock_in        (clk),
    .reset_in        (rst),
    .load_en_in      (ld),
    .load_addr_in    (la),
    .load_data_in    (ldat),
    .start_in        (st),
    .start_addr_in   (sa),
    .stop_in         (sp),
    .instr_ready_in  (rdy),
    .instr_out       (instr),
    .instr_valid_out (valid),
    .pc_out          (pc),
    .busy_out        (busy),
    .done_out        (done),
    .issued_count_out(cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] wrd(input int i);
    return 32'hA000_0000 | 32'(i);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0;
    end else if (!m_run) begin
      if (ld) m_mem[la] = ldat;
      if (sp) m_done = 0;
      else if (st) begin
        m_run = 1; m_done = 0; m_pc = int'(sa); m_cnt = 0;
      end
    end else begin
      if (rdy) begin
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        m_pc  = (m_pc + 1) % DEPTH;
      end
      if (sp) m_run = 0;
    end
    if (m_run && m_mem[m_pc] == HALT) begin
      m_run = 0; m_done = 1;
    end
  endtask

  task automatic check_model();
    check("m_valid", 32'(valid), 32'(m_run));
    check("m_busy",  32'(busy),  32'(m_run));
    check("m_done",  32'(done),  32'(m_done));
    check("m_count", 32'(cnt),   32'(m_cnt));
    if (m_run) check("m_instr", instr, m_mem[m_pc]);
    if (m_run || m_done) check("m_pc", 32'(pc), 32'(m_pc));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic quiet();
    rst = 0; ld = 0; la = 0; ldat = 0; st = 0; sa = 0; sp = 0;
  endtask

  task automatic load_prog(input int n);
    quiet();
    for (int i = 0; i <= n; i++) begin
      ld = 1; la = 4'(i); ldat = (i == n) ? HALT : wrd(i);
      tick();
    end
    quiet();
  endtask

  initial begin
    quiet();
    rdy = 0;
    rst = 1;
    tick();
    tick();
    check("rst_instr", instr, 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    rst = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ld = 1; la = 4'(i); ldat = 32'h1111_0000 + 32'(i);
      tick();
    end
    quiet();

    // Basic run: A,B,C then HALT.
    tbl[0] = '{1, 4'd0, WA,   0, 4'd0, 0, 0, 0, 32'd0, 4'd0, 0, 0, 16'd0};
    tbl[1] = '{1, 4'd1, WB,   0, 4'd0, 0, 0, 0, 32'd0, 4'd0, 0, 0, 16'd0};
    tbl[2] = '{1, 4'd2, WC,   0, 4'd0, 0, 0, 0, 32'd0, 4'd0, 0, 0, 16'd0};
    tbl[3] = '{1, 4'd3, HALT, 0, 4'd0, 0, 0, 0, 32'd0, 4'd0, 0, 0, 16'd0};
    tbl[4] = '{0, 4'd0, 32'd0, 1, 4'd0, 0, 1, 1, WA, 4'd0, 1, 0, 16'd0};
    tbl[5] = '{0, 4'd0, 32'd0, 0, 4'd0, 0, 1, 1, WB, 4'd1, 1, 0, 16'd1};
    tbl[6] = '{0, 4'd0, 32'd0, 0, 4'd0, 0, 1, 1, WC, 4'd2, 1, 0, 16'd2};
    tbl[7] = '{0, 4'd0, 32'd0, 0, 4'd0, 0, 1, 0, 32'd0, 4'd3, 0, 1, 16'd3};
    tbl[8] = '{0, 4'd0, 32'd0, 0, 4'd0, 0, 1, 0, 32'd0, 4'd3, 0, 1, 16'd3};
    for (int i = 0; i < 9; i++) begin
      ld = tbl[i].ld; la = tbl[i].la; ldat = tbl[i].ldat;
      st = tbl[i].st; sa = tbl[i].sa; sp = tbl[i].sp; rdy = tbl[i].rdy;
      tick();
      check("t_valid", 32'(valid), 32'(tbl[i].ev));
      check("t_busy",  32'(busy),  32'(tbl[i].eb));
      check("t_done",  32'(done),  32'(tbl[i].ed));
      check("t_count", 32'(cnt),   32'(tbl[i].ec));
      if (tbl[i].ev) check("t_instr", instr, tbl[i].ei);
      if (tbl[i].ev || tbl[i].ed) check("t_pc", 32'(pc), 32'(tbl[i].epc));
    end
    quiet();

    // Back-pressure: hold for 5 cycles at pc 2, then resume.
    load_prog(8);
    rdy = 1; st = 1; sa = 0;
    tick();
    quiet();
    tick();
    tick();
    rdy = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_pc", 32'(pc), 32'd2);
      check("hold_instr", instr, wrd(2));
      check("hold_cnt", 32'(cnt), 32'd2);
    end
    rdy = 1;
    tick();
    check("resume_pc", 32'(pc), 32'd3);
    check("resume_instr", instr, wrd(3));
    for (int i = 0; i < 8; i++) tick();
    check("resume_done", 32'(done), 32'd1);
    check("resume_cnt", 32'(cnt), 32'd8);

    // PC wrap from DEPTH-1 to 0 onto HALT.
    ld = 1; la = 4'd15; ldat = WA; tick();
    ld = 1; la = 4'd0; ldat = HALT; tick();
    quiet();
    st = 1; sa = 4'd15; rdy = 1;
    tick();
    quiet();
    check("wrap_pc15", 32'(pc), 32'd15);
    check("wrap_instr", instr, WA);
    tick();
    check("wrap_done", 32'(done), 32'd1);
    check("wrap_pc0", 32'(pc), 32'd0);
    check("wrap_cnt", 32'(cnt), 32'd1);

    // HALT at the start address: DONE immediately, nothing issued.
    st = 1; sa = 4'd0;
    tick();
    quiet();
    check("halt_start_done", 32'(done), 32'd1);
    check("halt_start_valid", 32'(valid), 32'd0);
    check("halt_start_cnt", 32'(cnt), 32'd0);

    // Load ignored in RUN; stop beats start.
    load_prog(8);
    st = 1; sa = 4'd0; rdy = 1;
    tick();
    quiet();
    ld = 1; la = 4'd5; ldat = 32'hDEAD_BEEF;
    tick();
    quiet();
    sp = 1; st = 1;
    tick();
    quiet();
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_valid", 32'(valid), 32'd0);
    check("stop_done", 32'(done), 32'd0);
    tick();
    check("stop_stays_idle", 32'(busy), 32'd0);
    rdy = 0; st = 1; sa = 4'd5;
    tick();
    quiet();
    check("readback", instr, wrd(5));

    // Reset mid-run, then rerun without reload.
    rst = 1;
    tick();
    check("mrst_instr", instr, 32'd0);
    check("mrst_pc", 32'(pc), 32'd0);
    check("mrst_valid", 32'(valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_cnt", 32'(cnt), 32'd0);
    quiet();
    rdy = 1; st = 1; sa = 4'd0;
    tick();
    quiet();
    for (int i = 0; i < 3; i++) begin
      check("rerun_instr", instr, wrd(i));
      tick();
    end

    // Dependent words issue back-to-back when the stall is not built in.
    quiet();
    sp = 1; tick(); quiet();
    ld = 1; la = 4'd0; ldat = 32'(5) << 11; tick();
    ld = 1; la = 4'd1; ldat = 32'(5) << 25; tick();
    ld = 1; la = 4'd2; ldat = HALT; tick();
    quiet();
    st = 1; sa = 4'd0; rdy = 1;
    tick();
    quiet();
    check("dep_w0", instr, 32'(5) << 11);
    tick();
    check("dep_w1_valid", 32'(valid), 32'd1);
    check("dep_w1", instr, 32'(5) << 25);
    tick();
    check("dep_done", 32'(done), 32'd1);
    check("dep_cnt", 32'(cnt), 32'd2);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst  = ($urandom_range(0, 199) == 0);
      ld   = !rst && ($urandom_range(0, 3) == 0);
      la   = 4'($urandom_range(0, 15));
      ldat = ($urandom_range(0, 5) == 0) ? HALT : $urandom;
      st   = ($urandom_range(0, 7) == 0);
      sa   = 4'($urandom_range(0, 15));
      sp   = ($urandom_range(0, 39) == 0);
      rdy  = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
